// File: rtl/memoria_ctrl.sv
// memoria_ctrl: game controller for the memory-match board.
// Moves a one-hot cursor over the cell array, takes two selections per turn,
// compares the two cell labels and either keeps the pair revealed and scores
// the current player, or shows the pair for HOLD_CYCLES cycles, hides it and
// passes the turn.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_next     one-cycle pulse, advances the cursor
//   btn_sel      one-cycle pulse, selects the cell under the cursor
//   labels_i     packed cell labels, cell i at [i*LABEL_W +: LABEL_W]
//   counter_o    one-hot cursor (all-zero once the game is over)
//   select_o     one-cycle one-hot select pulse
//   par_o        keep-revealed bit per cell (matched | pending)
//   player_o     current player
//   score0_o     player 0 pair count (saturating)
//   score1_o     player 1 pair count (saturating)
//   game_over_o  high once every cell is matched
module memoria_ctrl #(
    parameter int unsigned N_CELLS     = 16,
    parameter int unsigned LABEL_W     = 4,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_next,
    input  logic                         btn_sel,
    input  logic [N_CELLS*LABEL_W-1:0]   labels_i,
    output logic [N_CELLS-1:0]           counter_o,
    output logic [N_CELLS-1:0]           select_o,
    output logic [N_CELLS-1:0]           par_o,
    output logic                         player_o,
    output logic [SCORE_W-1:0]           score0_o,
    output logic [SCORE_W-1:0]           score1_o,
    output logic                         game_over_o
);

    localparam int unsigned IDX_W = $clog2(N_CELLS);
    localparam int unsigned TMR_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] ST_FIRST     = 3'd0;
    localparam logic [2:0] ST_SECOND    = 3'd1;
    localparam logic [2:0] ST_COMPARE   = 3'd2;
    localparam logic [2:0] ST_MISS_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    logic [2:0]         state_q,   state_d;
    logic [IDX_W-1:0]   cursor_q,  cursor_d;
    logic [IDX_W-1:0]   idx_a_q,   idx_a_d;
    logic [IDX_W-1:0]   idx_b_q,   idx_b_d;
    logic [N_CELLS-1:0] matched_q, matched_d;
    logic [N_CELLS-1:0] pending_q, pending_d;
    logic [TMR_W-1:0]   timer_q,   timer_d;
    logic               player_q,  player_d;
    logic [SCORE_W-1:0] score0_q,  score0_d;
    logic [SCORE_W-1:0] score1_q,  score1_d;
    logic [N_CELLS-1:0] select_q,  select_d;
    logic [N_CELLS-1:0] counter_q, counter_d;
    logic [N_CELLS-1:0] par_q,     par_d;
    logic               over_q,    over_d;

    logic               in_turn;
    logic               sel_ok;
    logic [LABEL_W-1:0] label_a;
    logic [LABEL_W-1:0] label_b;

    assign label_a = labels_i[idx_a_q*LABEL_W +: LABEL_W];
    assign label_b = labels_i[idx_b_q*LABEL_W +: LABEL_W];

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        idx_a_d   = idx_a_q;
        idx_b_d   = idx_b_q;
        matched_d = matched_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        player_d  = player_q;
        score0_d  = score0_q;
        score1_d  = score1_q;
        select_d  = '0;

        in_turn = (state_q == ST_FIRST) || (state_q == ST_SECOND);
        // Select is judged against the cursor before any same-cycle advance.
        sel_ok  = in_turn && btn_sel && !matched_q[cursor_q] && !pending_q[cursor_q];

        if (sel_ok) begin
            select_d[cursor_q]  = 1'b1;
            pending_d[cursor_q] = 1'b1;
            if (state_q == ST_FIRST) begin
                idx_a_d = cursor_q;
                state_d = ST_SECOND;
            end else begin
                idx_b_d = cursor_q;
                state_d = ST_COMPARE;
            end
        end

        if (in_turn && btn_next) begin
            if (cursor_q == IDX_W'(N_CELLS - 1)) begin
                cursor_d = '0;
            end else begin
                cursor_d = cursor_q + 1'b1;
            end
        end

        case (state_q)
            ST_COMPARE: begin
                if (label_a == label_b) begin
                    matched_d[idx_a_q] = 1'b1;
                    matched_d[idx_b_q] = 1'b1;
                    pending_d          = '0;
                    if (!player_q) begin
                        if (score0_q != '1) score0_d = score0_q + 1'b1;
                    end else begin
                        if (score1_q != '1) score1_d = score1_q + 1'b1;
                    end
                    state_d = (&matched_d) ? ST_DONE : ST_FIRST;
                end else begin
                    // Counts HOLD_CYCLES-1 down to 0, one cycle per value.
                    timer_d = TMR_W'(HOLD_CYCLES - 1);
                    state_d = ST_MISS_HOLD;
                end
            end
            ST_MISS_HOLD: begin
                if (timer_q == '0) begin
                    pending_d = '0;
                    player_d  = ~player_q;
                    state_d   = ST_FIRST;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: ;
        endcase

        // Output registers are loaded from next-state values so they track
        // the state they describe without an extra cycle of lag.
        counter_d = '0;
        if (state_d != ST_DONE) counter_d[cursor_d] = 1'b1;
        par_d  = matched_d | pending_d;
        over_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FIRST;
            cursor_q  <= '0;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            matched_q <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            player_q  <= 1'b0;
            score0_q  <= '0;
            score1_q  <= '0;
            select_q  <= '0;
            counter_q <= N_CELLS'(1);
            par_q     <= '0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            idx_a_q   <= idx_a_d;
            idx_b_q   <= idx_b_d;
            matched_q <= matched_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            player_q  <= player_d;
            score0_q  <= score0_d;
            score1_q  <= score1_d;
            select_q  <= select_d;
            counter_q <= counter_d;
            par_q     <= par_d;
            over_q    <= over_d;
        end
    end

    assign counter_o   = counter_q;
    assign select_o    = select_q;
    assign par_o       = par_q;
    assign player_o    = player_q;
    assign score0_o    = score0_q;
    assign score1_o    = score1_q;
    assign game_over_o = over_q;

endmodule
